// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button_conditioner block and its per-line
// channel: the line state encoding, default parameter values and small
// constant helpers used to size counters.
// Optional feature macro: BTN_AUTOREPEAT_EN (HOLD/REPEAT states are only
// reachable when it is defined).
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HOLD     = 2'd2,
    REPEAT   = 2'd3
  } btn_state_t;

  localparam int DEF_TICK_DIV  = 5000;
  localparam int DEF_HIST      = 8;
  localparam int DEF_REP_DELAY = 250;
  localparam int DEF_REP_RATE  = 60;

  // Number of bits needed to hold the values 0..value-1 (at least 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
// Bundles the board-facing raw inputs and the conditioned outputs of the
// button_conditioner.
//   btn_raw     raw active-high board lines
//   btn_level   debounced level per line
//   btn_press   one-cycle press pulse per line (also auto-repeat pulses)
//   btn_release one-cycle release pulse per line
//   tick        shared debounce sample strobe
// Modports: master = the side that drives btn_raw and consumes the results,
//           slave  = the conditioner itself.
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
  parameter int N_BTN = 8
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             tick;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  tick
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output tick
  );
endinterface

// File: rtl/button_conditioner_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One conditioned input line: 2-FF synchroniser, sample history shifted on
// each tick, RELEASED/PRESSED state machine and (with BTN_AUTOREPEAT_EN)
// the HOLD/REPEAT auto-repeat counter.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   tick         shared sample strobe from the top-level prescaler
//   btn_raw      raw asynchronous line
//   btn_level    registered debounced level
//   btn_press    registered one-cycle press / repeat pulse
//   btn_release  registered one-cycle release pulse
// Optional feature macro: BTN_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int HIST      = DEF_HIST,
  parameter int REP_DELAY = DEF_REP_DELAY,
  parameter int REP_RATE  = DEF_REP_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  logic sync_meta;
  logic btn_s;

  // Only the HIST-1 most recent samples are kept; together with the
  // current synchronised value they form the full HIST-sample window.
  logic [HIST-2:0] hist;
  logic [HIST-1:0] nxt;
  logic            all_ones;
  logic            all_zeros;

  btn_state_t state, state_n;
  logic       level_n, press_n, release_n;

  assign nxt       = {hist, btn_s};
  assign all_ones  = &nxt;
  assign all_zeros = ~|nxt;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = clog2(max2(REP_DELAY, REP_RATE) + 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_n, rep_cnt_inc;

  assign rep_cnt_inc = rep_cnt + 1'b1;
`endif

  // Next-state logic. A full window of equal samples on a tick is the only
  // thing that moves the line between released and pressed; release is
  // checked before any repeat so both can never pulse together.
  always_comb begin
    state_n   = state;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_n = rep_cnt;
`endif
    case (state)
      RELEASED: begin
        if (tick && all_ones) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
        end
      end
      default: begin
        if (tick && all_zeros) begin
          state_n   = RELEASED;
          level_n   = 1'b0;
          release_n = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_n = '0;
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        else begin
          case (state)
            PRESSED: begin
              // The cycle after acceptance is never a tick, so moving to
              // HOLD here loses no tick from the delay count.
              state_n   = HOLD;
              rep_cnt_n = '0;
            end
            HOLD: begin
              if (tick) begin
                if (rep_cnt_inc == REP_W'(REP_DELAY)) begin
                  state_n   = REPEAT;
                  press_n   = 1'b1;
                  rep_cnt_n = '0;
                end else begin
                  rep_cnt_n = rep_cnt_inc;
                end
              end
            end
            REPEAT: begin
              if (tick) begin
                if (rep_cnt_inc == REP_W'(REP_RATE)) begin
                  press_n   = 1'b1;
                  rep_cnt_n = '0;
                end else begin
                  rep_cnt_n = rep_cnt_inc;
                end
              end
            end
            default: begin
              state_n = state;
            end
          endcase
        end
`endif
      end
    endcase
  end

  // Synchroniser, sample history, state and registered outputs. Reset
  // clears everything silently, so a reset while pressed gives no release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta   <= 1'b0;
      btn_s       <= 1'b0;
      hist        <= '0;
      state       <= RELEASED;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      sync_meta   <= btn_raw;
      btn_s       <= sync_meta;
      if (tick) hist <= nxt[HIST-2:0];
      state       <= state_n;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt     <= rep_cnt_n;
`endif
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Front-end input stage: synchronises and debounces N_BTN raw board lines
// on a shared sample strobe, producing a clean level plus one-cycle press
// and release pulses per line.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  button_conditioner_if.slave (btn_raw in; btn_level, btn_press,
//        btn_release, tick out)
// Optional feature macro: BTN_AUTOREPEAT_EN enables hold-to-repeat, with
// the first repeat after REP_DELAY ticks and then one every REP_RATE ticks.
// ---------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN     = 8,
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int HIST      = DEF_HIST,
  parameter int REP_DELAY = DEF_REP_DELAY,
  parameter int REP_RATE  = DEF_REP_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  localparam int CNT_W = clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [N_BTN-1:0] level_w, press_w, release_w;

  // The strobe is a plain compare on the prescaler, so it is high during
  // the last clock of every TICK_DIV-clock period.
  assign tick = (cnt == CNT_LAST);

  // Prescaler shared by all lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .HIST      (HIST),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (bus.btn_raw[g]),
      .btn_level   (level_w[g]),
      .btn_press   (press_w[g]),
      .btn_release (release_w[g])
    );
  end

  assign bus.tick        = tick;
  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with N_BTN=4, TICK_DIV=4,
// HIST=4, REP_DELAY=3, REP_RATE=2. A behavioural model predicts every
// output each cycle from run lengths of equal samples and tick arithmetic.
// Honours BTN_AUTOREPEAT_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_BTN     = 4;
  localparam int TICK_DIV  = 4;
  localparam int HIST      = 4;
  localparam int REP_DELAY = 3;
  localparam int REP_RATE  = 2;

  logic clk;
  logic rst;

  button_conditioner_if #(.N_BTN(N_BTN)) bus ();

  button_conditioner #(
    .N_BTN     (N_BTN),
    .TICK_DIV  (TICK_DIV),
    .HIST      (HIST),
    .REP_DELAY (REP_DELAY),
    .REP_RATE  (REP_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int passes;

  // Model state: cycle index since reset release, raw values two and one
  // cycles back (the synchroniser delay), per-line run lengths of equal
  // samples, accepted level and the tick number of the accepted press.
  int         cyc;
  int         tick_count;
  logic [3:0] raw_m1, raw_m2;
  int         ones_run  [N_BTN];
  int         zeros_run [N_BTN];
  int         press_tick[N_BTN];
  logic [3:0] exp_level, exp_press, exp_release;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    cyc         = 0;
    tick_count  = 0;
    raw_m1      = '0;
    raw_m2      = '0;
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    for (int i = 0; i < N_BTN; i++) begin
      ones_run[i]   = 0;
      zeros_run[i]  = HIST;
      press_tick[i] = 0;
    end
  endtask

  // Called at a falling edge: compare outputs, drive the next raw value,
  // advance the model by one clock and move to the next falling edge.
  task automatic stepCycle(input logic [3:0] raw_next);
    logic       tick_now;
    logic [3:0] smp;
    int         d;
    tick_now = ((cyc % TICK_DIV) == TICK_DIV - 1);
    checkOutput("tick",    32'(bus.tick),        32'(tick_now));
    checkOutput("level",   32'(bus.btn_level),   32'(exp_level));
    checkOutput("press",   32'(bus.btn_press),   32'(exp_press));
    checkOutput("release", 32'(bus.btn_release), 32'(exp_release));

    bus.btn_raw = raw_next;
    smp    = raw_m2;
    raw_m2 = raw_m1;
    raw_m1 = raw_next;

    exp_press   = '0;
    exp_release = '0;
    if (tick_now) begin
      tick_count++;
      for (int i = 0; i < N_BTN; i++) begin
        if (smp[i]) begin
          ones_run[i]++;
          zeros_run[i] = 0;
        end else begin
          zeros_run[i]++;
          ones_run[i] = 0;
        end
        if (!exp_level[i] && ones_run[i] >= HIST) begin
          exp_level[i]  = 1'b1;
          exp_press[i]  = 1'b1;
          press_tick[i] = tick_count;
        end else if (exp_level[i] && zeros_run[i] >= HIST) begin
          exp_level[i]   = 1'b0;
          exp_release[i] = 1'b1;
        end else if (exp_level[i]) begin
          d = tick_count - press_tick[i];
`ifdef BTN_AUTOREPEAT_EN
          if (d >= REP_DELAY && ((d - REP_DELAY) % REP_RATE) == 0) exp_press[i] = 1'b1;
`else
          if (d < 0) exp_press[i] = 1'b1;
`endif
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] value, input int cycles);
    for (int k = 0; k < cycles; k++) stepCycle(value);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_level"},   32'(bus.btn_level),   32'd0);
    checkOutput({tag, "_press"},   32'(bus.btn_press),   32'd0);
    checkOutput({tag, "_release"}, 32'(bus.btn_release), 32'd0);
    checkOutput({tag, "_tick"},    32'(bus.tick),        32'd0);
  endtask

  initial begin
    logic [3:0] pattern;
    logic [3:0] v;
    int         len;
    checks = 0;
    passes = 0;
    resetModel();

    // Reset held with all lines high: everything stays quiet.
    rst = 1'b1;
    bus.btn_raw = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkAllZero("in_reset");
    end

    // Release reset on a falling edge; that edge starts cycle 0.
    bus.btn_raw = 4'h0;
    rst = 1'b0;
    resetModel();
    applyStimulus(4'b0000, 12);

    // Clean press and release of line 0.
    applyStimulus(4'b0001, 30);
    applyStimulus(4'b0000, 30);

    // Line 1 bounces every 3 clocks, then settles high.
    for (int k = 0; k < 40; k++) stepCycle(((k / 3) % 2) != 0 ? 4'b0010 : 4'b0000);
    applyStimulus(4'b0010, 30);

    // Lines 2 and 3 step high together, then everything releases.
    applyStimulus(4'b1110, 30);
    applyStimulus(4'b0000, 30);

    // Random segments with occasional single-cycle glitches.
    for (int s = 0; s < 24; s++) begin
      pattern = 4'($urandom_range(0, 15));
      len     = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        v = pattern;
        if ($urandom_range(0, 7) == 0) v = v ^ 4'(1 << $urandom_range(0, 3));
        stepCycle(v);
      end
    end
    applyStimulus(4'b0000, 30);

    // Line 0 pressed, then reset asserted between clock edges.
    applyStimulus(4'b0001, 30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    applyStimulus(4'b0001, 40);
    applyStimulus(4'b0000, 30);

    // Long hold on line 0 (40 ticks) to exercise repeat behaviour.
    applyStimulus(4'b0001, 40 * TICK_DIV);
    applyStimulus(4'b0000, 30);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
